uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (434 = 115200 baud at 50 MHz); legal range 4..65535.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rx  input  1  serial line (idle high, 8N1, LSB first), asynchronous to clk.
REQ-005 rx_data  output  8  last correctly framed byte.
REQ-006 rx_valid  output  1  high while rx_data holds an unread byte.
REQ-007 rx_ack  input  1  one-cycle read strobe from the I/O register file; consumes rx_data.
REQ-008 frame_err  output  1  sticky: a stop bit was sampled low.
REQ-009 overrun  output  1  sticky: a byte completed while rx_valid was already high and unacknowledged.
REQ-010 err_clr  input  1  one-cycle strobe clearing frame_err and overrun.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s; input-to-rx_s latency is 2 cycles.
REQ-013 A bit-period counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index SHALL be used; the counter clears on every state change and on every sample.
REQ-014 States: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: rx_s==0 -> START, counter cleared.
REQ-016 START: at counter == CLKS_PER_BIT/2-1 (integer division), sample rx_s; 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, no flag, no output change).
REQ-017 DATA: at counter == CLKS_PER_BIT-1, sample rx_s into a shift register at position bit index (LSB first); after the sample with index 7 -> STOP, else increment the index.
REQ-018 STOP: at counter == CLKS_PER_BIT-1, sample rx_s; 1 -> deliver byte, go to IDLE; 0 -> set frame_err, discard byte, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_s==1, then go to IDLE (break condition never produces bytes).
REQ-020 Delivery: on the cycle after the good stop sample, rx_data SHALL hold the new byte and rx_valid SHALL be 1.
REQ-021 rx_ack while rx_valid=1 clears rx_valid next cycle; rx_data is unchanged. rx_ack with rx_valid=0 is ignored.
REQ-022 Delivery and rx_ack in the same cycle: new byte loaded, rx_valid stays 1, overrun not set.
REQ-023 Delivery with rx_valid=1 and no rx_ack: rx_data overwritten with the new byte, rx_valid stays 1, overrun set.
REQ-024 err_clr clears both sticky flags; a flag-setting event coinciding with err_clr takes priority (flag ends set).
REQ-025 rx_data SHALL change only on delivery.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 Reset asserted mid-frame abandons the frame; after release the block waits in IDLE for the next falling edge, and the partial byte is never delivered.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 8'hA5 with a valid frame -> rx_data=8'hA5, rx_valid=1 about 154 cycles after the start edge; frame_err=0; rx_ack then gives rx_valid=0 and rx_data still 8'hA5.
REQ-029 Drive rx low for 5 cycles, then high -> returns to IDLE; rx_valid, frame_err and rx_data unchanged; busy pulses.
REQ-030 Send 8'h3C with the stop bit low and rx held low for a further 40 cycles -> frame_err=1, rx_valid=0, state WAIT_HIGH until rx rises; then send 8'h01 -> delivered correctly; err_clr -> frame_err=0.
REQ-031 Send 8'h11 then 8'h22 with no rx_ack -> rx_data=8'h22, overrun=1; repeat with rx_ack in the delivery cycle of 8'h22 -> overrun=0, rx_valid=1.
REQ-032 Assert rst_n low during DATA bit 4 of 8'hFF, release, then send 8'h5A -> only 8'h5A is delivered, and no flags are set.
REQ-033 Send back-to-back frames 8'h00 and 8'hFF with no idle gap between them, acknowledging each -> both bytes are delivered in order with no errors.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with single-entry holding register.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial line (idle high, LSB first), asynchronous to clk
//   rx_data    last correctly framed byte (changes only on delivery)
//   rx_valid   high while rx_data holds an unread byte
//   rx_ack     one-cycle read strobe, consumes rx_data
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte arrived while the previous one was unread
//   err_clr    one-cycle strobe clearing frame_err and overrun
//   busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta_q, rx_s_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          deliver;
  logic          frame_set;

  // Two-flop synchronizer, reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive sequencer. The bit counter free-runs and is cleared on every
  // state change and every sample point.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_set = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // Re-check the line mid start bit to reject glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must return high before a new frame.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register and sticky flags. Delivery wins over rx_ack for
  // rx_valid; flag-setting events win over err_clr.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (deliver) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end

    if (frame_set) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;
  // Edge index (counted from the start-bit edge) whose following clock
  // edge samples the stop bit: 2 sync + 1 idle + CPB/2 + 9*CPB - 1.
  localparam int DELIV_CYC = 2 + 1 + CPB / 2 + 9 * CPB - 1;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_valid = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delivery monitor: a byte is delivered when rx_valid rises or rx_data
  // changes; each delivery is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((rx_valid && !prev_valid) || (rx_data !== prev_data)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL delivery: got byte %h, expected no delivery", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rx_data !== mon_exp) begin
            n_fail++;
            $display("FAIL delivery: got byte %h, expected %h", rx_data, mon_exp);
          end
        end
      end
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  // Drives n_cyc cycles of a frame; entered and left at posedge+1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_cyc,
                            input int clr_cyc, input int n_cyc, output int first_valid);
    logic [9:0] frame;
    frame       = {stop, b, 1'b0};
    first_valid = -1;
    for (int c = 0; c < n_cyc; c++) begin
      rx      = frame[c / CPB];
      rx_ack  = (c == ack_cyc);
      err_clr = (c == clr_cyc);
      @(posedge clk); #1;
      if (first_valid < 0 && rx_valid) first_valid = c;
    end
    rx_ack  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rx      = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    idle_cycles(3);
    n_checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
    rst_n = 1'b1;
    idle_cycles(4);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_frame_a5();
    int fv;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, FRAME_CYC, fv);
    n_checks++;
    if (fv < DELIV_CYC - 4 || fv > DELIV_CYC + 4) begin
      n_fail++;
      $display("FAIL a5_latency: got %0d cycles, expected about %0d", fv, DELIV_CYC);
    end
    n_checks++;
    if ({rx_data, rx_valid, frame_err} !== {8'hA5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL a5_delivered: got data=%h v=%b fe=%b, expected a5 1 0",
               rx_data, rx_valid, frame_err);
    end
    pulse_ack();
    n_checks++;
    if ({rx_data, rx_valid} !== {8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL a5_ack: got data=%h v=%b, expected a5 0", rx_data, rx_valid);
    end
    pulse_ack();
    n_checks++;
    if ({rx_data, rx_valid, overrun} !== {8'hA5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ack_when_empty: got data=%h v=%b ov=%b, expected a5 0 0",
               rx_data, rx_valid, overrun);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d0;
    logic       v0;
    logic       f0;
    logic       saw_busy;
    d0 = rx_data; v0 = rx_valid; f0 = frame_err;
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      saw_busy |= busy;
    end
    rx = 1'b1;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(posedge clk); #1;
      saw_busy |= busy;
    end
    n_checks++;
    if ({saw_busy, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL glitch_busy: got pulsed=%b now=%b, expected 1 0", saw_busy, busy);
    end
    n_checks++;
    if ({rx_data, rx_valid, frame_err} !== {d0, v0, f0}) begin
      n_fail++;
      $display("FAIL glitch_unchanged: got data=%h v=%b fe=%b, expected %h %b %b",
               rx_data, rx_valid, frame_err, d0, v0, f0);
    end
  endtask

  task automatic test_frame_err();
    int fv;
    send_frame(8'h3C, 1'b0, -1, -1, FRAME_CYC, fv);
    idle_cycles(40);
    n_checks++;
    if ({frame_err, rx_valid, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL break_hold: got fe=%b v=%b busy=%b, expected 1 0 1",
               frame_err, rx_valid, busy);
    end
    rx = 1'b1;
    idle_cycles(4);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_release: got busy=%b, expected 0", busy);
    end
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, -1, -1, FRAME_CYC, fv);
    n_checks++;
    if ({rx_data, rx_valid, frame_err} !== {8'h01, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL after_break: got data=%h v=%b fe=%b, expected 01 1 1",
               rx_data, rx_valid, frame_err);
    end
    pulse_ack();
    pulse_clr();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: got fe=%b, expected 0", frame_err);
    end
    // err_clr coincides with the low stop-bit sample: the flag must win.
    send_frame(8'h3C, 1'b0, -1, DELIV_CYC, FRAME_CYC, fv);
    rx = 1'b1;
    idle_cycles(4);
    n_checks++;
    if ({frame_err, rx_valid, rx_data} !== {1'b1, 1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL set_beats_clr: got fe=%b v=%b data=%h, expected 1 0 01",
               frame_err, rx_valid, rx_data);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL frame_err_pending: got %0d undelivered, expected 0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    int fv;
    pulse_clr();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, FRAME_CYC, fv);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, -1, -1, FRAME_CYC, fv);
    n_checks++;
    if ({rx_data, rx_valid, overrun, frame_err} !== {8'h22, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL overrun_set: got data=%h v=%b ov=%b fe=%b, expected 22 1 1 0",
               rx_data, rx_valid, overrun, frame_err);
    end
    pulse_clr();
    n_checks++;
    if ({overrun, rx_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL overrun_clr: got ov=%b v=%b, expected 0 1", overrun, rx_valid);
    end
    pulse_ack();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, FRAME_CYC, fv);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, DELIV_CYC, -1, FRAME_CYC, fv);
    n_checks++;
    if ({rx_data, rx_valid, overrun} !== {8'h22, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ack_at_delivery: got data=%h v=%b ov=%b, expected 22 1 0",
               rx_data, rx_valid, overrun);
    end
    pulse_ack();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL overrun_pending: got %0d undelivered, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int fv;
    // Stop inside data bit 4 of 8'hFF.
    send_frame(8'hFF, 1'b1, -1, -1, CPB + 4 * CPB + 6, fv);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, rx_valid, rx_data} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b v=%b data=%h, expected 0 0 00",
               busy, rx_valid, rx_data);
    end
    rx = 1'b1;
    @(posedge clk); #1;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(6 * CPB);
    n_checks++;
    if ({busy, rx_valid, frame_err, overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_reset_idle: got busy=%b v=%b fe=%b ov=%b, expected 0 0 0 0",
               busy, rx_valid, frame_err, overrun);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1, FRAME_CYC, fv);
    n_checks++;
    if ({rx_data, rx_valid, frame_err, overrun} !== {8'h5A, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_5a: got data=%h v=%b fe=%b ov=%b, expected 5a 1 0 0",
               rx_data, rx_valid, frame_err, overrun);
    end
    pulse_ack();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_pending: got %0d undelivered, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int fv;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, -1, -1, FRAME_CYC, fv);
    send_frame(8'hFF, 1'b1, 2 * CPB, -1, FRAME_CYC, fv);
    n_checks++;
    if ({rx_data, rx_valid, frame_err, overrun} !== {8'hFF, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got data=%h v=%b fe=%b ov=%b, expected ff 1 0 0",
               rx_data, rx_valid, frame_err, overrun);
    end
    pulse_ack();
    n_checks++;
    if ({rx_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_ack: got v=%b busy=%b, expected 0 0", rx_valid, busy);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_pending: got %0d undelivered, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    idle_cycles(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
